// File: rtl/reset_sequencer_if.sv
// Reset-sequencer bus: per-domain active-low resets, completion flag and the
// optional soft-reset handshake (present only when RESET_SEQ_SOFT_RST_EN is defined).
interface reset_sequencer_if #(
    parameter int STAGES = 3
);
    logic [STAGES-1:0] rst_stage_n;
    logic              done;
`ifdef RESET_SEQ_SOFT_RST_EN
    logic              soft_rst_req;
    logic              soft_rst_ack;

    modport master (
        output rst_stage_n,
        output done,
        output soft_rst_ack,
        input  soft_rst_req
    );

    modport slave (
        input  rst_stage_n,
        input  done,
        input  soft_rst_ack,
        output soft_rst_req
    );
`else
    modport master (
        output rst_stage_n,
        output done
    );

    modport slave (
        input  rst_stage_n,
        input  done
    );
`endif
endinterface

// File: rtl/reset_sequencer.sv
// Holds all reset domains for HOLD_CYCLES, then releases them one by one every
// STAGE_DELAY cycles. Define RESET_SEQ_SOFT_RST_EN to allow re-running the sequence from DONE.
module reset_sequencer #(
    parameter int STAGES      = 3,
    parameter int HOLD_CYCLES = 16,
    parameter int STAGE_DELAY = 8
) (
    input  logic               clk,
    input  logic               rst,
    reset_sequencer_if.master  bus
);

    localparam int MAX_WAIT = (HOLD_CYCLES > STAGE_DELAY) ? HOLD_CYCLES : STAGE_DELAY;
    localparam int CNT_W    = $clog2(MAX_WAIT) + 1;
    localparam int IDX_W    = $clog2(STAGES) + 1;

    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(STAGE_DELAY - 1);
    localparam logic [IDX_W-1:0] STAGE_LAST = IDX_W'(STAGES - 1);

    typedef enum logic [1:0] {
        ST_HOLD,
        ST_RELEASE,
        ST_DONE
    } state_t;

    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [IDX_W-1:0]  r_idx;
    logic [STAGES-1:0] r_rst_stage_n;
    logic              r_done;
`ifdef RESET_SEQ_SOFT_RST_EN
    logic              r_soft_rst_ack;
`endif

    // NOTE: every state bit is assigned with <= so all registers update from
    // the same pre-edge values; a blocking = here would chain updates within one edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= ST_HOLD;
            r_cnt         <= '0;
            r_idx         <= '0;
            r_rst_stage_n <= '0;
            r_done        <= 1'b0;
`ifdef RESET_SEQ_SOFT_RST_EN
            r_soft_rst_ack <= 1'b0;
`endif
        end else begin
`ifdef RESET_SEQ_SOFT_RST_EN
            r_soft_rst_ack <= 1'b0;
`endif
            case (r_state)
                ST_HOLD: begin
                    if (r_cnt == HOLD_LAST) begin
                        r_cnt   <= '0;
                        r_idx   <= '0;
                        r_state <= ST_RELEASE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                ST_RELEASE: begin
                    if (r_cnt == DELAY_LAST) begin
                        r_cnt <= '0;
                        r_idx <= r_idx + 1'b1;
                        // Bits only ever go 0->1 here; reassertion happens solely on reset paths.
                        for (int i = 0; i < STAGES; i++) begin
                            if (r_idx == IDX_W'(i)) begin
                                r_rst_stage_n[i] <= 1'b1;
                            end
                        end
                        if (r_idx == STAGE_LAST) begin
                            r_done  <= 1'b1;
                            r_state <= ST_DONE;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                ST_DONE: begin
`ifdef RESET_SEQ_SOFT_RST_EN
                    // Requests are only honoured once the sequence has completed.
                    if (bus.soft_rst_req) begin
                        r_rst_stage_n  <= '0;
                        r_done         <= 1'b0;
                        r_cnt          <= '0;
                        r_idx          <= '0;
                        r_soft_rst_ack <= 1'b1;
                        r_state        <= ST_HOLD;
                    end
`else
                    r_state <= ST_DONE;
`endif
                end

                default: begin
                    r_state <= ST_HOLD;
                end
            endcase
        end
    end

    assign bus.rst_stage_n = r_rst_stage_n;
    assign bus.done        = r_done;
`ifdef RESET_SEQ_SOFT_RST_EN
    assign bus.soft_rst_ack = r_soft_rst_ack;
`endif

endmodule

// File: tb/tb_reset_sequencer.sv
// Scoreboard bench for reset_sequencer: default-parameter instance plus a 1/1/1 instance;
// output changes are matched against queued {edge, value} expectations.
module tb_reset_sequencer;

    typedef struct {
        int         edge_n;
        logic [4:0] val;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc;

    exp_t q_a[$];
    exp_t q_b[$];
    exp_t e_a;
    exp_t e_b;
    logic [4:0] prev_a = '0;
    logic [1:0] prev_b = '0;

    reset_sequencer_if #(.STAGES(3)) bus_a ();
    reset_sequencer_if #(.STAGES(1)) bus_b ();

    reset_sequencer #(.STAGES(3), .HOLD_CYCLES(16), .STAGE_DELAY(8)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    reset_sequencer #(.STAGES(1), .HOLD_CYCLES(1), .STAGE_DELAY(1)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    logic       ack_a;
    logic [4:0] obs_a;
    logic [1:0] obs_b;
`ifdef RESET_SEQ_SOFT_RST_EN
    assign ack_a = bus_a.soft_rst_ack;
`else
    assign ack_a = 1'b0;
`endif
    assign obs_a = {ack_a, bus_a.done, bus_a.rst_stage_n};
    assign obs_b = {bus_b.done, bus_b.rst_stage_n};

    // Rising edges since the last rst deassertion.
    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic push_a(input int e, input logic [4:0] v);
        exp_t x;
        x.edge_n = e;
        x.val    = v;
        q_a.push_back(x);
    endtask

    task automatic push_power_up_a(input int base);
        push_a(base + 24, 5'b00001);
        push_a(base + 32, 5'b00011);
        push_a(base + 40, 5'b01111);
    endtask

    task automatic release_rst();
        exp_t x;
        x.edge_n = 2;
        x.val    = 5'b00011;
        q_b.push_back(x);
        @(negedge clk);
        #2 rst = 1'b0;
    endtask

    task automatic wait_cyc(input int n);
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (cyc != n && k < 500);
        check("wait_cyc", cyc, n);
    endtask

    // Output monitor: every change outside reset must match the head of the scoreboard.
    always @(negedge clk) begin
        if (rst) begin
            prev_a = obs_a;
            prev_b = obs_b;
        end else begin
            if (obs_a != prev_a) begin
                if (q_a.size() == 0) begin
                    check("a_unexpected", obs_a, prev_a);
                end else begin
                    e_a = q_a.pop_front();
                    check("a_value", obs_a, e_a.val);
                    check("a_edge", cyc, e_a.edge_n);
                end
                prev_a = obs_a;
            end
            if (obs_b != prev_b) begin
                if (q_b.size() == 0) begin
                    check("b_unexpected", obs_b, prev_b);
                end else begin
                    e_b = q_b.pop_front();
                    check("b_value", obs_b, e_b.val[1:0]);
                    check("b_edge", cyc, e_b.edge_n);
                end
                prev_b = obs_b;
            end
        end
    end

    initial begin
`ifdef RESET_SEQ_SOFT_RST_EN
        bus_a.soft_rst_req = 1'b0;
        bus_b.soft_rst_req = 1'b0;
`endif
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        check("reset_a", obs_a, 5'b00000);
        check("reset_b", obs_b, 2'b00);

        // Power-up sequence, aborted by rst at edge 30 after stage 0 is out.
        push_power_up_a(0);
        release_rst();
        wait_cyc(30);
        check("pre_abort_stage", obs_a, 5'b00001);
        #2 rst = 1'b1;
        #1;
        check("abort_a", obs_a, 5'b00000);
        check("abort_b", obs_b, 2'b00);
        check("b_drained", q_b.size(), 0);
        q_a.delete();
        repeat (2) @(negedge clk);
        check("abort_hold_a", obs_a, 5'b00000);

        // Full sequence repeats from scratch.
        push_power_up_a(0);
        release_rst();
        wait_cyc(50);
        check("rerun_done_a", obs_a, 5'b01111);
        check("a_drained", q_a.size(), 0);
        check("b_drained2", q_b.size(), 0);

`ifdef RESET_SEQ_SOFT_RST_EN
        // One-cycle request in DONE, sampled on edge 56.
        wait_cyc(55);
        bus_a.soft_rst_req = 1'b1;
        push_a(56, 5'b10000);
        push_a(57, 5'b00000);
        push_power_up_a(56);
        wait_cyc(56);
        bus_a.soft_rst_req = 1'b0;
        wait_cyc(100);
        check("soft_drained", q_a.size(), 0);

        // Request held from edge 10 is ignored until DONE, then acked once.
        #2 rst = 1'b1;
        release_rst();
        push_power_up_a(0);
        push_a(41, 5'b10000);
        push_a(42, 5'b00000);
        push_power_up_a(41);
        wait_cyc(9);
        bus_a.soft_rst_req = 1'b1;
        begin
            int k;
            k = 0;
            while (!bus_a.soft_rst_ack && k < 60) begin
                @(negedge clk);
                k++;
            end
        end
        check("held_ack_seen", bus_a.soft_rst_ack, 1'b1);
        check("held_ack_edge", cyc, 41);
        bus_a.soft_rst_req = 1'b0;
        wait_cyc(85);
        check("held_done_a", obs_a, 5'b01111);
        check("held_drained", q_a.size(), 0);
        check("held_b_drained", q_b.size(), 0);
`else
        // DONE is terminal: nothing may move until the next rst.
        wait_cyc(150);
        check("terminal_a", obs_a, 5'b01111);
        check("terminal_b", obs_b, 2'b11);
        check("terminal_drained", q_a.size(), 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/reset_sequencer.md
RESET_SEQUENCER -- requirements
Module: reset_sequencer

Interface
REQ-001 SHALL have parameter STAGES, default 3, meaning the number of reset domains sequenced (legal range 1..8).
REQ-002 SHALL have parameter HOLD_CYCLES, default 16, meaning the minimum number of clk cycles all domains stay in reset (legal range >= 1).
REQ-003 SHALL have parameter STAGE_DELAY, default 8, meaning the number of clk cycles between consecutive domain releases (legal range >= 1).
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state changes occur on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port rst_stage_n, output, STAGES bits: active-low per-domain resets; bit i is released before bit i+1.
REQ-007 SHALL have port done, output, 1 bit: high when all domains are released.
REQ-008 SHALL have port soft_rst_req, input, 1 bit: level request to re-run the full sequence (present only under RESET_SEQ_SOFT_RST_EN).
REQ-009 SHALL have port soft_rst_ack, output, 1 bit: one-cycle acknowledge of soft_rst_req (present only under RESET_SEQ_SOFT_RST_EN).

Function
REQ-010 SHALL implement the states HOLD, RELEASE and DONE, plus a cycle counter of width clog2(max(HOLD_CYCLES, STAGE_DELAY)) + 1 and a stage index of width clog2(STAGES) + 1.
REQ-011 SHALL, in HOLD, increment the counter each edge; on the edge where counter == HOLD_CYCLES-1 it SHALL clear the counter, set index = 0 and enter RELEASE.
REQ-012 SHALL, in RELEASE, increment the counter each edge; on the edge where counter == STAGE_DELAY-1 it SHALL set rst_stage_n[index] = 1, increment index and clear the counter.
REQ-013 SHALL, on the edge that releases bit STAGES-1, set done = 1 and enter DONE in that same edge.
REQ-014 SHALL release bit i on rising edge HOLD_CYCLES + (i+1)*STAGE_DELAY after rst deasserts; with defaults, bits 0/1/2 release at edges 24/32/40 and done rises at edge 40.
REQ-015 SHALL drive all outputs directly from flops, with no combinational path from any input to any output.
REQ-016 SHALL never re-assert an already released bit except on rst or an accepted soft reset.
REQ-017 SHALL, on an accepted soft reset, drive all rst_stage_n bits to 0 and done to 0, and clear the counter.

Reset
REQ-018 SHALL, while rst is high, asynchronously force state = HOLD, counter = 0, index = 0, rst_stage_n = all 0, done = 0 and soft_rst_ack = 0, regardless of the clock.
REQ-019 SHALL, on rst asserted mid-sequence or in DONE, abort immediately and restart from HOLD after deassertion, with no partial release retained.

Configuration
REQ-020 SHALL, with RESET_SEQ_SOFT_RST_EN defined, sample soft_rst_req only in DONE; when it is sampled high, the next edge SHALL apply REQ-017, pulse soft_rst_ack for exactly one cycle and enter HOLD.
REQ-021 SHALL, with RESET_SEQ_SOFT_RST_EN defined, ignore soft_rst_req in HOLD/RELEASE without issuing an ack; a request still held high SHALL be accepted on the first DONE cycle.
REQ-022 SHALL, with RESET_SEQ_SOFT_RST_EN defined, re-trigger the sequence if soft_rst_req remains high in a later DONE cycle, because the requester must drop the request after the ack.
REQ-023 SHALL, without RESET_SEQ_SOFT_RST_EN, omit the soft_rst_req/soft_rst_ack ports, make DONE terminal until rst, and otherwise match REQ-010..REQ-019.

Verification
REQ-024 Power-up with defaults, rst released -> rst_stage_n = 000 until edge 24, 001 at edge 24, 011 at edge 32, 111 at edge 40; done = 1 at edge 40.
REQ-025 rst pulsed high at edge 30 (stage 0 released) -> rst_stage_n = 000 and done = 0 immediately; after release, the full 24/32/40 timing repeats.
REQ-026 (SOFT_RST_EN) soft_rst_req = 1 for one cycle in DONE -> next edge rst_stage_n = 000, done = 0, ack = 1 for one cycle; releases follow at +24/+32/+40 from that edge.
REQ-027 (SOFT_RST_EN) soft_rst_req held from edge 10 until ack -> no ack before edge 40; ack on the edge after done first rises; the sequence reruns.
REQ-028 STAGES=1, HOLD_CYCLES=1, STAGE_DELAY=1 -> rst_stage_n = 1 and done = 1 at edge 2 after rst release.
